// File: rtl/hack_cpu_ctrl_if.sv
// Bus bundle between the Hack sequencer and its program ROM, data RAM and ALU.
// The master side is the sequencer; the slave side is the memories plus the ALU.
interface hack_cpu_ctrl_if #(
    parameter int PC_W = 15
) ();

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_data;

    logic            dmem_req;
    logic            dmem_we;
    logic [PC_W-1:0] dmem_addr;
    logic [15:0]     dmem_wdata;
    logic            dmem_ack;
    logic [15:0]     dmem_rdata;

    logic [15:0]     alu_x;
    logic [15:0]     alu_y;
    logic            alu_zx;
    logic            alu_nx;
    logic            alu_zy;
    logic            alu_ny;
    logic            alu_f;
    logic            alu_no;
    logic [15:0]     alu_out;
    logic            alu_zr;
    logic            alu_ng;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata,
        output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        input  alu_out, alu_zr, alu_ng
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata,
        input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
        output alu_out, alu_zr, alu_ng
    );

endinterface

// File: rtl/hack_cpu_ctrl.sv
// Multicycle Hack CPU sequencer: fetch, decode, optional M read, execute, optional M write.
// Define HACK_CTRL_INSTRET_EN to add a 32-bit retired-instruction counter output.
module hack_cpu_ctrl #(
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    hack_cpu_ctrl_if.master       bus
`ifdef HACK_CTRL_INSTRET_EN
    ,
    output logic [31:0]           instret
`endif
);

    typedef enum logic [2:0] {
        START,
        FETCH,
        DECODE,
        MREAD,
        EXEC,
        MWRITE
    } state_t;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [PC_W-1:0] waddr, waddr_n;
    logic [15:0]     a, a_n;
    logic [15:0]     d, d_n;
    logic [15:0]     ir, ir_n;
    logic [15:0]     m, m_n;
    logic [15:0]     wdata, wdata_n;
    logic [PC_W-1:0] pc_inc;
    logic            jump;

    assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign jump   = (ir[2] & bus.alu_ng) | (ir[1] & bus.alu_zr) |
                    (ir[0] & ~bus.alu_ng & ~bus.alu_zr);

    assign bus.imem_req   = (state == FETCH);
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = (state == MREAD) || (state == MWRITE);
    assign bus.dmem_we    = (state == MWRITE);
    assign bus.dmem_addr  = (state == MWRITE) ? waddr : a[PC_W-1:0];
    assign bus.dmem_wdata = wdata;

    assign bus.alu_x  = d;
    assign bus.alu_y  = ir[12] ? m : a;
    assign bus.alu_zx = ir[11];
    assign bus.alu_nx = ir[10];
    assign bus.alu_zy = ir[9];
    assign bus.alu_ny = ir[8];
    assign bus.alu_f  = ir[7];
    assign bus.alu_no = ir[6];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= START;
            pc    <= RESET_PC;
            a     <= '0;
            d     <= '0;
            ir    <= '0;
            m     <= '0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            a     <= a_n;
            d     <= d_n;
            ir    <= ir_n;
            m     <= m_n;
            waddr <= waddr_n;
            wdata <= wdata_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        a_n     = a;
        d_n     = d;
        ir_n    = ir;
        m_n     = m;
        waddr_n = waddr;
        wdata_n = wdata;
        case (state)
            START: state_n = FETCH;
            FETCH: begin
                if (bus.imem_ack) begin
                    ir_n    = bus.imem_data;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                if (!ir[15]) begin
                    a_n     = ir;
                    pc_n    = pc_inc;
                    state_n = FETCH;
                end else begin
                    state_n = ir[12] ? MREAD : EXEC;
                end
            end
            MREAD: begin
                if (bus.dmem_ack) begin
                    m_n     = bus.dmem_rdata;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                // Jump target and write address both use A as it was before this write.
                if (ir[4]) d_n = bus.alu_out;
                if (ir[5]) a_n = bus.alu_out;
                pc_n = jump ? a[PC_W-1:0] : pc_inc;
                if (ir[3]) begin
                    wdata_n = bus.alu_out;
                    waddr_n = a[PC_W-1:0];
                    state_n = MWRITE;
                end else begin
                    state_n = FETCH;
                end
            end
            MWRITE: begin
                if (bus.dmem_ack) state_n = FETCH;
            end
            default: state_n = START;
        endcase
    end

`ifdef HACK_CTRL_INSTRET_EN
    logic retire;

    assign retire = ((state == DECODE) && !ir[15]) ||
                    ((state == EXEC) && !ir[3]) ||
                    ((state == MWRITE) && bus.dmem_ack);

    always_ff @(posedge clk) begin
        if (reset) instret <= '0;
        else if (retire) instret <= instret + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed self-checking bench for hack_cpu_ctrl with a behavioural Hack ALU and
// scripted ROM/RAM responses; expectations are queued before each instruction.
module tb_hack_cpu_ctrl;

    logic clk;
    logic reset;
    hack_cpu_ctrl_if #(.PC_W(15)) bus ();
`ifdef HACK_CTRL_INSTRET_EN
    logic [31:0] instret;
`endif

    hack_cpu_ctrl #(.PC_W(15), .RESET_PC(15'd0)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus)
`ifdef HACK_CTRL_INSTRET_EN
        ,
        .instret (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y,
                                            input logic zx, input logic nx, input logic zy,
                                            input logic ny, input logic f, input logic no);
        logic [15:0] xx;
        logic [15:0] yy;
        logic [15:0] r;
        xx = zx ? 16'h0 : x;
        xx = nx ? ~xx : xx;
        yy = zy ? 16'h0 : y;
        yy = ny ? ~yy : yy;
        r  = f ? (xx + yy) : (xx & yy);
        return no ? ~r : r;
    endfunction

    assign bus.alu_out = hackAlu(bus.alu_x, bus.alu_y, bus.alu_zx, bus.alu_nx,
                                 bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no);
    assign bus.alu_zr  = (bus.alu_out == 16'h0);
    assign bus.alu_ng  = bus.alu_out[15];

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   retired = 0;

    logic [5:0]  capCtrl;
    logic [15:0] capY;
    int          dmCycles;
    logic [14:0] dmAddr;
    logic        dmWe;
    logic [15:0] dmWdata;
    bit          dmStable;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic expectVal(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic timeoutFail(input string tag);
        checks++;
        errors++;
        $error("[TB] FAIL %s: observed=timeout expected=response", tag);
    endtask

    task automatic waitFetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.imem_req) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (!ok) timeoutFail("fetch_wait");
    endtask

    // Feed one instruction, serve its data accesses after dly wait cycles, and
    // return the cycle count from the fetch-ack cycle until the next fetch.
    task automatic applyStimulus(input logic [15:0] instr, input int dly,
                                 input logic [15:0] rdata, output int cycles);
        bit ok;
        int waited;
        waitFetch(ok);
        if (!ok) begin
            cycles = -1;
            return;
        end
        bus.imem_data = instr;
        bus.imem_ack  = 1'b1;
        cyc();
        bus.imem_ack  = 1'b0;
        bus.imem_data = 16'hDEAD;
        cycles   = 1;
        waited   = 0;
        dmCycles = 0;
        dmStable = 1'b1;
        while (!bus.imem_req && cycles < 60) begin
            bus.dmem_ack = 1'b0;
            capCtrl = {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no};
            capY    = bus.alu_y;
            if (bus.dmem_req) begin
                if (dmCycles == 0) begin
                    dmAddr  = bus.dmem_addr;
                    dmWe    = bus.dmem_we;
                    dmWdata = bus.dmem_wdata;
                end else if (bus.dmem_addr !== dmAddr || bus.dmem_we !== dmWe ||
                             bus.dmem_wdata !== dmWdata) begin
                    dmStable = 1'b0;
                end
                dmCycles++;
                if (waited == dly) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = rdata;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
            cyc();
            cycles++;
        end
        bus.dmem_ack = 1'b0;
        if (!bus.imem_req) timeoutFail("exec_wait");
        else retired++;
    endtask

    int  n;
    bit  ok;

    initial begin
        reset          = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_data  = 16'h0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 16'h0;
        cyc();
        cyc();

        expectVal("rst_imem_req", 32'd0);
        expectVal("rst_dmem_req", 32'd0);
        expectVal("rst_dmem_we", 32'd0);
        expectVal("rst_dmem_wdata", 32'd0);
        expectVal("rst_d", 32'd0);
        expectVal("rst_pc", 32'd0);
        checkOutput(32'(bus.imem_req));
        checkOutput(32'(bus.dmem_req));
        checkOutput(32'(bus.dmem_we));
        checkOutput(32'(bus.dmem_wdata));
        checkOutput(32'(bus.alu_x));
        checkOutput(32'(bus.imem_addr));
        reset = 1'b0;
        cyc();
        expectVal("start_to_fetch", 32'd1);
        checkOutput(32'(bus.imem_req));

        // @5
        expectVal("ainst_cycles", 32'd2);
        expectVal("ainst_pc", 32'd1);
        expectVal("ainst_a", 32'd5);
        applyStimulus(16'h0005, 0, 16'h0, n);
        checkOutput(32'(n));
        checkOutput(32'(bus.imem_addr));
        checkOutput(32'(bus.dmem_addr));

        // D=A
        expectVal("dA_cycles", 32'd3);
        expectVal("dA_ctrl", 32'b110000);
        expectVal("dA_y", 32'd5);
        expectVal("dA_d", 32'd5);
        expectVal("dA_pc", 32'd2);
        expectVal("dA_no_dmem", 32'd0);
        applyStimulus(16'hEC10, 0, 16'h0, n);
        checkOutput(32'(n));
        checkOutput(32'(capCtrl));
        checkOutput(32'(capY));
        checkOutput(32'(bus.alu_x));
        checkOutput(32'(bus.imem_addr));
        checkOutput(32'(dmCycles));

        // M=D with ack delayed 3 cycles
        expectVal("mw_cycles", 32'd7);
        expectVal("mw_req_cycles", 32'd4);
        expectVal("mw_we", 32'd1);
        expectVal("mw_addr", 32'd5);
        expectVal("mw_wdata", 32'd5);
        expectVal("mw_stable", 32'd1);
        expectVal("mw_pc", 32'd3);
        applyStimulus(16'hE308, 3, 16'h0, n);
        checkOutput(32'(n));
        checkOutput(32'(dmCycles));
        checkOutput(32'(dmWe));
        checkOutput(32'(dmAddr));
        checkOutput(32'(dmWdata));
        checkOutput(32'(dmStable));
        checkOutput(32'(bus.imem_addr));

        // D=M reading 0x8000
        expectVal("mr_cycles", 32'd4);
        expectVal("mr_req_cycles", 32'd1);
        expectVal("mr_we", 32'd0);
        expectVal("mr_addr", 32'd5);
        expectVal("mr_y", 32'h8000);
        expectVal("mr_d", 32'h8000);
        applyStimulus(16'hFC10, 0, 16'h8000, n);
        checkOutput(32'(n));
        checkOutput(32'(dmCycles));
        checkOutput(32'(dmWe));
        checkOutput(32'(dmAddr));
        checkOutput(32'(capY));
        checkOutput(32'(bus.alu_x));

        // D;JLT taken with D negative
        applyStimulus(16'h000A, 0, 16'h0, n);
        expectVal("jlt_taken_pc", 32'd10);
        applyStimulus(16'hE304, 0, 16'h0, n);
        checkOutput(32'(bus.imem_addr));

        // D;JLT not taken with D=5
        applyStimulus(16'h0005, 0, 16'h0, n);
        applyStimulus(16'hEC10, 0, 16'h0, n);
        applyStimulus(16'h000A, 0, 16'h0, n);
        expectVal("jlt_not_taken_pc", 32'd14);
        applyStimulus(16'hE304, 0, 16'h0, n);
        checkOutput(32'(bus.imem_addr));

        // 0;JMP goes to A
        expectVal("jmp_pc", 32'd10);
        applyStimulus(16'hEA87, 0, 16'h0, n);
        checkOutput(32'(bus.imem_addr));

        // PC wrap from 0x7FFF
        applyStimulus(16'h7FFF, 0, 16'h0, n);
        expectVal("jmp_7fff_pc", 32'h7FFF);
        applyStimulus(16'hEA87, 0, 16'h0, n);
        checkOutput(32'(bus.imem_addr));
        expectVal("wrap_pc", 32'd0);
        expectVal("wrap_d", 32'h7FFF);
        applyStimulus(16'hEC10, 0, 16'h0, n);
        checkOutput(32'(bus.imem_addr));
        checkOutput(32'(bus.alu_x));

        // AMD=D+1 writes to the old A
        applyStimulus(16'h0007, 0, 16'h0, n);
        expectVal("amd_cycles", 32'd4);
        expectVal("amd_waddr", 32'd7);
        expectVal("amd_wdata", 32'h8000);
        expectVal("amd_d", 32'h8000);
        expectVal("amd_a_low", 32'd0);
        applyStimulus(16'hE7F8, 0, 16'h0, n);
        checkOutput(32'(n));
        checkOutput(32'(dmAddr));
        checkOutput(32'(dmWdata));
        checkOutput(32'(bus.alu_x));
        checkOutput(32'(bus.dmem_addr));

        // A=M;JMP jumps to the pre-write A
        applyStimulus(16'h0014, 0, 16'h0, n);
        expectVal("amjmp_raddr", 32'h14);
        expectVal("amjmp_pc", 32'd20);
        expectVal("amjmp_a", 32'h33);
        applyStimulus(16'hFC27, 0, 16'h0033, n);
        checkOutput(32'(dmAddr));
        checkOutput(32'(bus.imem_addr));
        checkOutput(32'(bus.dmem_addr));

`ifdef HACK_CTRL_INSTRET_EN
        expectVal("instret_count", 32'(retired));
        checkOutput(instret);
`endif

        // Reset during MWRITE with ack withheld
        waitFetch(ok);
        bus.imem_data = 16'hE308;
        bus.imem_ack  = 1'b1;
        cyc();
        bus.imem_ack  = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.dmem_req && bus.dmem_we) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (!ok) timeoutFail("mwrite_wait");
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        expectVal("mrst_dmem_req", 32'd0);
        expectVal("mrst_imem_req", 32'd0);
        expectVal("mrst_pc", 32'd0);
        expectVal("mrst_d", 32'd0);
        expectVal("mrst_a", 32'd0);
        checkOutput(32'(bus.dmem_req));
        checkOutput(32'(bus.imem_req));
        checkOutput(32'(bus.imem_addr));
        checkOutput(32'(bus.alu_x));
        checkOutput(32'(bus.dmem_addr));
`ifdef HACK_CTRL_INSTRET_EN
        expectVal("mrst_instret", 32'd0);
        checkOutput(instret);
`endif
        cyc();
        expectVal("mrst_fetch", 32'd1);
        checkOutput(32'(bus.imem_req));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Multicycle Hack CPU sequencer: the producer side of the 16-bit Hack ALU interface.
- Fetches instructions over a req/ack instruction port and decodes A- and C-instructions.
- Drives the ALU operands and the six control bits (zx, nx, zy, ny, f, no), consumes out/zr/ng, and owns the A, D and PC registers.
- Reads and writes data memory over a req/ack port; sits between program ROM, data RAM and an external ALU instance.

Parameters:
- PC_W, 15, width of PC and of all memory addresses.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= PC).
- imem_ack  in  1  fetch complete; imem_data valid this cycle.
- imem_data  in  16  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req=1.
- dmem_addr  out  PC_W  data address (= A[PC_W-1:0]).
- dmem_wdata  out  16  write data.
- dmem_ack  in  1  access complete; dmem_rdata valid on a read.
- dmem_rdata  in  16  read data (M).
- alu_x  out  16  = D.
- alu_y  out  16  = A if instr[12]=0, else latched M.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  = instr[11], [10], [9], [8], [7], [6].
- alu_out  in  16  ALU result.
- alu_zr  in  1  result zero.
- alu_ng  in  1  result negative.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset state: state=START, PC=RESET_PC, A=0, D=0, IR=0, M latch=0, imem_req=0, dmem_req=0, dmem_we=0, dmem_wdata=0.
- Reset mid-operation: any pending req drops on the cycle after reset is sampled. Reset has priority over every other event.
- Request outputs are decoded from the state register only.

State machine:
- START -> FETCH after one cycle.
- FETCH: imem_req=1, imem_addr=PC, held stable until imem_ack. On ack, IR<=imem_data and go to DECODE.
- DECODE, A-instruction (IR[15]=0): A<=IR, PC<=PC+1, go to FETCH.
- DECODE, C-instruction: if IR[12]=1 go to MREAD, else go to EXEC. IR[14:13] are ignored.
- MREAD: dmem_req=1, we=0, addr=A. On ack, M<=dmem_rdata and go to EXEC.
- EXEC: the ALU is driven combinationally and its result is sampled at the end of EXEC.
  - If IR[4], D<=alu_out.
  - If IR[5], A<=alu_out.
  - If IR[3], latch wdata<=alu_out and waddr<=old A, then go to MWRITE.
  - Otherwise go to FETCH.
  - Jump taken = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr).
  - If taken, PC<=old A[PC_W-1:0]; else PC<=PC+1.
  - "Old A" always means A before this instruction's write, so A=M;JMP jumps to the pre-write A.
- MWRITE: dmem_req=1, we=1, addr=waddr, wdata latched. On ack go to FETCH.

Handshake rules:
- ack may arrive in the same cycle req first rises (zero wait). Minimum one cycle per state.
- ack while the matching req=0 is ignored.
- addr, we and wdata are stable while req=1.

Latency (zero-wait memory):
- A-instruction: 2 cycles.
- C-instruction without M: 3 cycles.
- +1 cycle for an M read; +1 cycle for an M write.

Arithmetic and boundaries:
- PC increments modulo 2^PC_W, so 0x7FFF -> 0 with no flag.
- A is 16 bits; only the low PC_W bits address memory.
- alu_* outputs in non-EXEC states carry the current values (don't-care to the ALU).
- Combined destinations are legal: with dest AMD, all three take alu_out and the write address is old A.

Optional Feature:
- Macro HACK_CTRL_INSTRET_EN.
- When defined: adds output port instret, 32 bits. It resets to 0, increments by 1 on the cycle each instruction retires, and wraps at 0xFFFFFFFF -> 0.
  - Retire cycle: DECODE for an A-instruction; EXEC without dest M; MWRITE on ack.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then imem_data=0x0005 with immediate ack -> 2 cycles later A=5, PC=1, imem_req=1 with imem_addr=1.
- 0x0005 then 0xEC10 (D=A) -> in EXEC alu_zx=1, nx=1, zy=0, ny=0, f=0, no=0, alu_y=5; D=5; PC=2; no dmem_req.
- A=5, D=5, then 0xE308 (M=D) with dmem_ack delayed 3 cycles -> dmem_req=1, we=1, addr=5, wdata=5 held stable for 4 cycles; then FETCH at PC+1.
- A=5, then 0xFC10 (D=M) with dmem_rdata=0x8000 -> read at addr 5 with we=0; alu_y=0x8000; D=0x8000.
- Jump cases:
  - 0x000A then 0xE304 (D;JLT) with D=0x8000 -> PC=10.
  - Same with D=5 -> PC=old PC+1.
  - 0xEA87 (0;JMP) -> PC=A.
  - PC=0x7FFF executing a non-jump instruction -> PC wraps to 0.
- Reset asserted for 1 cycle during MWRITE with ack withheld -> dmem_req=0 next cycle, PC=0, A=D=0, imem_req=0 in START, 1 the cycle after. With HACK_CTRL_INSTRET_EN, instret=0.
